// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Module  : mips_pkg
// Brief   : Shared fetch-stage types, instruction field positions and defaults.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
//------------------------------------------------------------------------------
// Module  : pc_next
// Brief   : Sequential and redirect target selection (jr > jump > branch > +4).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_next (
   input  logic [31:0] i_pc,
   input  logic [25:0] i_jidx,
   input  logic [31:0] i_signimm,
   input  logic [31:0] i_jr_target,
   input  logic        i_pcsrc,
   input  logic        i_jump,
   input  logic        i_jr,
   output logic [31:0] o_pcplus4,
   output logic [31:0] o_next_pc
);

   logic [31:0] w_pcplus4;
   logic [31:0] w_jump_tgt;
   logic [31:0] w_branch_tgt;

   assign w_pcplus4    = i_pc + 32'd4;
   assign w_jump_tgt   = {w_pcplus4[31:28], i_jidx, 2'b00};
   // Shift drops signimm[31:30]; carry out of the add is discarded too.
   assign w_branch_tgt = w_pcplus4 + (i_signimm << 2);

   always_comb begin
      o_next_pc = w_pcplus4;
      if (i_jr)
         o_next_pc = i_jr_target;
      else if (i_jump)
         o_next_pc = w_jump_tgt;
      else if (i_pcsrc)
         o_next_pc = w_branch_tgt;
   end

   assign o_pcplus4 = w_pcplus4;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : fetch_unit
// Brief   : Instruction fetch FSM with pc, instruction register and retire count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic        jr,
   input  logic [31:0] signimm,
   input  logic [31:0] jr_target,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pcplus4,
   output logic [31:0] instret,
   output logic        addr_err
);

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instret;
   logic        r_addr_err;
   logic [31:0] w_next_pc;
   logic        w_misaligned;
   logic        w_retire;

   pc_next u_pc_next (
      .i_pc        (r_pc),
      .i_jidx      (r_instr[25:0]),
      .i_signimm   (signimm),
      .i_jr_target (jr_target),
      .i_pcsrc     (pcsrc),
      .i_jump      (jump),
      .i_jr        (jr),
      .o_pcplus4   (pcplus4),
      .o_next_pc   (w_next_pc)
   );

   assign w_misaligned = jr && (jr_target[1:0] != 2'b00);
   assign w_retire     = (r_state == ST_EXEC) && !stall;

   always_comb begin
      w_next_state = r_state;
      imem_req     = 1'b0;
      instr_valid  = 1'b0;
      case (r_state)
         ST_IDLE:  w_next_state = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready)
               w_next_state = ST_EXEC;
         end
         ST_EXEC: begin
            instr_valid = 1'b1;
            if (!stall)
               w_next_state = w_misaligned ? ST_HALT : ST_FETCH;
         end
         default:  w_next_state = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= 32'h0;
         r_instret  <= 32'h0;
         r_addr_err <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == ST_FETCH) && imem_ready)
            r_instr <= imem_rdata;
         // A misaligned jr does not retire: pc and count stay on the faulting op.
         if (w_retire) begin
            if (w_misaligned) begin
               r_addr_err <= 1'b1;
            end else begin
               r_pc      <= w_next_pc;
               r_instret <= r_instret + 32'd1;
            end
         end
      end
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign instr     = r_instr;
   assign instret   = r_instret;
   assign addr_err  = r_addr_err;
   assign op        = r_instr[OP_MSB:OP_LSB];
   assign funct     = r_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_unit
// Brief   : Vector table plus scoreboard of expected fetch addresses for fetch_unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        pcsrc, jump, jr;
   logic [31:0] signimm, jr_target;
   logic [31:0] instr;
   logic [5:0]  op, funct;
   logic        instr_valid;
   logic [31:0] pc, pcplus4, instret;
   logic        addr_err;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .stall       (stall),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .jr          (jr),
      .signimm     (signimm),
      .jr_target   (jr_target),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pcplus4     (pcplus4),
      .instret     (instret),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        pcsrc;
      logic        jump;
      logic        jr;
      logic [31:0] signimm;
      logic [31:0] jr_target;
      int          stall_n;
      int          ready_dly;
      logic [31:0] exp_next;
   } vec_t;

   vec_t        vecs[10];
   logic [31:0] sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fetch();
      int k = 0;
      while (!imem_req && k < 20) begin
         step();
         k++;
      end
      chk("fetch_reached", {31'h0, imem_req}, 32'h1);
   endtask

   task automatic clear_redirect();
      pcsrc = 1'b0; jump = 1'b0; jr = 1'b0;
      signimm = 32'h0; jr_target = 32'h0;
   endtask

   initial begin
      logic [31:0] model_pc;
      logic [31:0] model_instret;
      logic [31:0] exp_addr;
      logic [31:0] w;

      //         instr         pcsrc jump  jr    signimm       jr_target     stl rdy exp_next
      vecs[0] = '{32'h2000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_0004};
      vecs[1] = '{32'h8C01_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 2, 32'h0000_0008};
      vecs[2] = '{32'h1000_003D, 1'b1, 1'b0, 1'b0, 32'h0000_003D, 32'h0000_0000, 0, 0, 32'h0000_0100};
      vecs[3] = '{32'h1422_FFFE, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 0, 1, 32'h0000_00FC};
      vecs[4] = '{32'h03E0_0008, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h3000_0010, 0, 0, 32'h3000_0010};
      vecs[5] = '{32'h0800_0040, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 0, 0, 32'h3000_0100};
      vecs[6] = '{32'h0000_0008, 1'b1, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0200, 5, 0, 32'h0000_0200};
      vecs[7] = '{32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0FFF_FFFC};
      vecs[8] = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 0, 32'h1000_0000};
      vecs[9] = '{32'h1000_8000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 0, 0, 32'h1000_0004};

      reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
      clear_redirect();
      #1;
      chk("rst_imem_req",     {31'h0, imem_req},    32'h0);
      chk("rst_instr_valid",  {31'h0, instr_valid}, 32'h0);
      chk("rst_pcplus4",      pcplus4,              32'h0000_0004);
      chk("rst_instr",        instr,                32'h0);
      chk("rst_instret",      instret,              32'h0);
      chk("rst_addr_err",     {31'h0, addr_err},    32'h0);
      step(); step();
      reset = 1'b1;
      chk("idle_imem_req",    {31'h0, imem_req},    32'h0);
      step();

      model_pc      = 32'h0;
      model_instret = 32'h0;
      sb.push_back(32'h0);

      foreach (vecs[i]) begin
         wait_fetch();
         exp_addr = sb.pop_front();
         chk($sformatf("v%0d_imem_addr", i), imem_addr, exp_addr);
         for (int d = 0; d < vecs[i].ready_dly; d++) begin
            imem_ready = 1'b0;
            step();
            chk($sformatf("v%0d_fetch_hold", i), {31'h0, imem_req}, 32'h1);
         end
         imem_rdata = vecs[i].instr;
         imem_ready = 1'b1;
         pcsrc = vecs[i].pcsrc; jump = vecs[i].jump; jr = vecs[i].jr;
         signimm = vecs[i].signimm; jr_target = vecs[i].jr_target;
         stall = (vecs[i].stall_n > 0);
         step();
         imem_rdata = 32'hDEAD_BEEF;
         imem_ready = (vecs[i].stall_n > 0);
         w = vecs[i].instr;
         chk($sformatf("v%0d_valid", i),   {31'h0, instr_valid}, 32'h1);
         chk($sformatf("v%0d_instr", i),   instr,   w);
         chk($sformatf("v%0d_op", i),      {26'h0, op},    {26'h0, w[31:26]});
         chk($sformatf("v%0d_funct", i),   {26'h0, funct}, {26'h0, w[5:0]});
         chk($sformatf("v%0d_pc", i),      pc,      model_pc);
         chk($sformatf("v%0d_pcplus4", i), pcplus4, model_pc + 32'd4);
         for (int s = 1; s < vecs[i].stall_n; s++) begin
            step();
            chk($sformatf("v%0d_stall_valid", i),   {31'h0, instr_valid}, 32'h1);
            chk($sformatf("v%0d_stall_pc", i),      pc,      model_pc);
            chk($sformatf("v%0d_stall_instr", i),   instr,   w);
            chk($sformatf("v%0d_stall_instret", i), instret, model_instret);
         end
         if (vecs[i].stall_n > 0) begin
            step();
            chk($sformatf("v%0d_stall_last_instr", i), instr, w);
         end
         stall = 1'b0;
         imem_ready = 1'b0;
         sb.push_back(vecs[i].exp_next);
         model_instret = model_instret + 32'd1;
         step();
         clear_redirect();
         chk($sformatf("v%0d_instret", i), instret, model_instret);
         chk($sformatf("v%0d_valid_drop", i), {31'h0, instr_valid}, 32'h0);
         model_pc = vecs[i].exp_next;
      end

      wait_fetch();
      exp_addr = sb.pop_front();
      chk("final_imem_addr", imem_addr, exp_addr);

      // Misaligned jr: sticky error, frozen registers, no further fetches.
      imem_rdata = 32'h03E0_0008;
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      jr = 1'b1; jr_target = 32'h0000_0402;
      step();
      clear_redirect();
      chk("halt_addr_err", {31'h0, addr_err},    32'h1);
      chk("halt_pc",       pc,                   model_pc);
      chk("halt_instret",  instret,              model_instret);
      for (int c = 0; c < 4; c++) begin
         imem_ready = 1'b1;
         step();
         chk("halt_imem_req",    {31'h0, imem_req},    32'h0);
         chk("halt_instr_valid", {31'h0, instr_valid}, 32'h0);
      end
      imem_ready = 1'b0;

      // Reset clears HALT; then reset again while a fetch is pending.
      reset = 1'b0;
      #1;
      chk("rst2_addr_err", {31'h0, addr_err}, 32'h0);
      chk("rst2_pc",       pc,                32'h0);
      step();
      reset = 1'b1;
      step();
      wait_fetch();
      imem_rdata = 32'hAAAA_0001;
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      step();
      wait_fetch();
      chk("rst3_fetch_addr", imem_addr, 32'h0000_0004);
      step(); step();
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      reset = 1'b0;
      #1;
      chk("rst3_instr",    instr,             32'h0);
      chk("rst3_imem_req", {31'h0, imem_req}, 32'h0);
      step(); step();
      chk("rst3_held_instr", instr, 32'h0);
      reset = 1'b1;
      imem_rdata = 32'h1234_5678;
      chk("rst3_idle_req", {31'h0, imem_req}, 32'h0);
      step();
      chk("rst3_late_ready_ignored", instr,     32'h0);
      chk("rst3_refetch_addr",       imem_addr, 32'h0);
      step();
      chk("rst3_new_instr",          instr,     32'h1234_5678);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address; equals pc.
REQ-006 imem_rdata  input  32  fetched instruction word; sampled only when imem_ready=1 in FETCH.
REQ-007 imem_ready  input  1  memory has imem_rdata valid this cycle.
REQ-008 stall  input  1  downstream holds the current instruction in EXEC.
REQ-009 pcsrc, jump, jr  input  1 each  redirect controls for the instruction in EXEC.
REQ-010 signimm  input  32  sign-extended immediate of the current instruction.
REQ-011 jr_target  input  32  register-file rs value for jr.
REQ-012 instr  output  32  instruction register contents.
REQ-013 op, funct  output  6 each  instr[31:26] and instr[5:0].
REQ-014 instr_valid  output  1  instr is live and control outputs derived from it are meaningful.
REQ-015 pc, pcplus4  output  32 each  address of instr; pc+4 (modulo 2^32).
REQ-016 instret  output  32  retired-instruction counter.
REQ-017 addr_err  output  1  sticky misaligned-jr flag.

Function
REQ-018 States: IDLE, FETCH, EXEC, HALT.
REQ-019 IDLE: one cycle after reset release, imem_req=0, then unconditionally FETCH.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1 load instr<=imem_rdata, go EXEC; otherwise stay, no timeout.
REQ-021 EXEC: imem_req=0, instr_valid=1; stall=1 holds state, pc, instr and counter unchanged.
REQ-022 EXEC with stall=0: pc<=next_pc, instret<=instret+1 (wraps 2^32-1 to 0), go FETCH; instr_valid=1 for exactly one non-stalled cycle per instruction.
REQ-023 next_pc priority: jr -> jr_target; else jump -> {pcplus4[31:28], instr[25:0], 2'b00}; else pcsrc -> pcplus4 + (signimm << 2); else pcplus4.
REQ-024 Simultaneous jr and jump/pcsrc: jr wins; jump and pcsrc together: jump wins.
REQ-025 jr with jr_target[1:0]!=0 and stall=0: addr_err<=1, pc unchanged, instret not incremented, go HALT.
REQ-026 HALT: imem_req=0, instr_valid=0, all registers frozen; exit only via reset.
REQ-027 Branch/jump target arithmetic is 32-bit, overflow discarded; pc[1:0] always 2'b00 except never reachable otherwise.
REQ-028 imem_ready outside FETCH is ignored; imem_rdata never sampled outside FETCH.
REQ-029 Redirect inputs are ignored outside EXEC.
REQ-030 op/funct are combinational slices of instr; no extra latency.

Reset
REQ-031 reset low: state<=IDLE, pc<=RESET_PC, instr<=0, instret<=0, addr_err<=0 immediately, independent of clk.
REQ-032 During reset: imem_req=0, instr_valid=0, pcplus4=RESET_PC+4.
REQ-033 Reset asserted mid-FETCH abandons the request; a late imem_ready after release is ignored until the new FETCH.

Structure
REQ-034 Shared package mips_pkg holds the state enum type, OP_MSB/OP_LSB/FUNCT field positions and the RESET_PC default constant.
REQ-035 One combinational sub-module pc_next computes pcplus4 and next_pc from pc, instr, signimm, jr_target, pcsrc, jump, jr.
REQ-036 fetch_unit holds the state machine, pc, instr, instret and addr_err registers only.

Verification
REQ-037 Reset release, imem_ready=1 always -> imem_addr sequence 0,4,8; instr_valid pulses every other cycle; instret=3 after third EXEC.
REQ-038 pc=0x100, signimm=0xFFFF_FFFE, pcsrc=1 -> next imem_addr=0x0FC.
REQ-039 pc=0x3000_0010, instr[25:0]=0x0000040, jump=1, pcsrc=1 -> next imem_addr=0x3000_0100.
REQ-040 stall=1 for 5 cycles in EXEC -> instr, pc, instret stable; single increment after stall drops.
REQ-041 jr=1, jr_target=0x0000_0402 -> addr_err=1, state HALT, imem_req=0 until reset.
REQ-042 reset low while FETCH waiting (imem_ready=0), imem_ready=1 during reset -> instr=0, first post-reset fetch at RESET_PC.
